// File: rtl/mult_seq_unit.sv
// ----------------------------------------------------------------------------
// mult_seq_unit
// Iterative shift-add multiplier for mult/multu, one multiplier bit per clock.
// Produces a 2*WIDTH-bit product as hiOut/loOut, with a one-cycle done /
// regWrite = 2'b10 strobe that drives the register bank's hi/lo write.
//
// Optional build macro:
//   MULT_EARLY_EXIT_EN - leave RUN as soon as the remaining multiplier bits are
//                        all zero, right-aligning the accumulator in one step.
// ----------------------------------------------------------------------------
module mult_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [1:0]       regWrite,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_reg_write;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg_in;
    logic [WIDTH:0]   w_sum;
    logic [PW-1:0]    w_acc_shift;
    logic [WIDTH-1:0] w_mplier_shift;
    logic [CW-1:0]    w_cnt_dec;
    logic             w_last;
    logic [PW-1:0]    w_acc_run;
    logic [PW-1:0]    w_result;

    // Signed operands are reduced to magnitudes; the most negative value maps
    // onto itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign w_mag_a  = (isSigned && opA[WIDTH-1]) ? (~opA + WIDTH'(1)) : opA;
    assign w_mag_b  = (isSigned && opB[WIDTH-1]) ? (~opB + WIDTH'(1)) : opB;
    assign w_neg_in = isSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);

    // One shift-add step: conditional add into the upper half, carry kept,
    // then the whole accumulator shifts right by one.
    assign w_sum          = {1'b0, r_acc[PW-1:WIDTH]}
                          + {1'b0, r_mcand & {WIDTH{r_mplier[0]}}};
    assign w_acc_shift    = {w_sum, r_acc[WIDTH-1:1]};
    assign w_mplier_shift = {1'b0, r_mplier[WIDTH-1:1]};
    assign w_cnt_dec      = r_cnt - CW'(1);

`ifdef MULT_EARLY_EXIT_EN
    logic w_mplier_zero;

    // Once no multiplier bits remain, the outstanding iterations are pure
    // shifts, so they collapse into one variable right shift.
    assign w_mplier_zero = (w_mplier_shift == '0);
    assign w_last        = (w_cnt_dec == '0) || w_mplier_zero;
    assign w_acc_run     = w_mplier_zero ? (w_acc_shift >> w_cnt_dec) : w_acc_shift;
`else
    assign w_last        = (w_cnt_dec == '0);
    assign w_acc_run     = w_acc_shift;
`endif

    // Apply the sign of the exact product to the magnitude product.
    assign w_result = r_neg ? (~r_acc + PW'(1)) : r_acc;

    // Control FSM and datapath registers; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_neg       <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_reg_write <= 2'b00;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_neg    <= w_neg_in;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_run;
                    r_mplier <= w_mplier_shift;
                    r_cnt    <= w_cnt_dec;
                    if (w_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // hi/lo keep the previous product until this point.
                    r_hi        <= w_result[PW-1:WIDTH];
                    r_lo        <= w_result[WIDTH-1:0];
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_reg_write <= 2'b10;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_reg_write <= 2'b00;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign regWrite = r_reg_write;
    assign hiOut    = r_hi;
    assign loOut    = r_lo;

endmodule

// File: tb/tb_mult_seq_unit.sv
// ----------------------------------------------------------------------------
// tb_mult_seq_unit
// Self-checking bench: directed vector table, hand-written sequences for the
// ignored-start and mid-operation reset cases, and random operations checked
// against a plain 64-bit arithmetic reference.
// Honours MULT_EARLY_EXIT_EN when computing expected latency.
// ----------------------------------------------------------------------------
module tb_mult_seq_unit;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic         isSigned;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         busy;
    logic         done;
    logic [1:0]   regWrite;
    logic [W-1:0] hiOut;
    logic [W-1:0] loOut;

    int n_checks = 0;
    int n_pass   = 0;

    mult_seq_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .isSigned (isSigned),
        .opA      (opA),
        .opB      (opB),
        .busy     (busy),
        .done     (done),
        .regWrite (regWrite),
        .hiOut    (hiOut),
        .loOut    (loOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference product: plain wide arithmetic on sign- or zero-extended operands.
    function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        return s ? 64'(sa * sb) : (ua * ub);
    endfunction

    // Cycles from the start edge to the done cycle (also the busy cycle count).
    function automatic int exp_lat(input logic [W-1:0] b, input logic s);
`ifdef MULT_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int           n;
        mag = (s && b[W-1]) ? (~b + W'(1)) : b;
        n = 1;
        for (int i = 0; i < int'(W); i++) if (mag[i]) n = i + 1;
        return n + 1;
`else
        return (b === b && s === s) ? int'(W) + 1 : 0;
`endif
    endfunction

    // Issue one operation and observe it until a couple of cycles past done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int lat, output int nbusy, output int ndone,
                          output int rw_bad);
        @(negedge clk);
        opA = a; opB = b; isSigned = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; nbusy = 0; ndone = 0; rw_bad = 0; hi = '0; lo = '0;
        for (int j = 0; j < 200; j++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) begin lat = j; hi = hiOut; lo = loOut; end
                if (regWrite !== 2'b10) rw_bad++;
            end else if (regWrite !== 2'b00) begin
                rw_bad++;
            end
            if (lat >= 0 && j >= lat + 2) break;
            // Operand changes mid-operation must not affect the result.
            opA = $urandom; opB = $urandom; isSigned = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic full_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        logic [W-1:0] hi, lo;
        int lat, nb, nd, rwb;
        run_op(a, b, s, hi, lo, lat, nb, nd, rwb);
        chk({tag, ".hi"},      64'(hi),  64'(ehi));
        chk({tag, ".lo"},      64'(lo),  64'(elo));
        chk({tag, ".latency"}, 64'(lat), 64'(exp_lat(b, s)));
        chk({tag, ".busy"},    64'(nb),  64'(exp_lat(b, s)));
        chk({tag, ".ndone"},   64'(nd),  64'd1);
        chk({tag, ".regwr"},   64'(rwb), 64'd0);
    endtask

    vec_t vecs[10];

    initial begin
        logic [W-1:0] hi, lo, a, b;
        logic [63:0]  p;
        logic         s;
        int           lat, nb, nd, rwb, glitch;
        logic [W-1:0] specials[6];

        vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
        vecs[3] = '{32'h80000000, 32'h00000002, 1'b0, 32'h00000001, 32'h00000000};
        vecs[4] = '{32'h00000007, 32'h00000000, 1'b1, 32'h00000000, 32'h00000000};
        vecs[5] = '{32'h00000006, 32'h00000007, 1'b1, 32'h00000000, 32'h0000002A};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001};
        vecs[7] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 32'hC0000000, 32'h80000000};
        vecs[8] = '{32'h12345678, 32'h00000001, 1'b0, 32'h00000000, 32'h12345678};
        vecs[9] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000000};

        specials[0] = 32'h00000000; specials[1] = 32'h00000001;
        specials[2] = 32'h7FFFFFFF; specials[3] = 32'h80000000;
        specials[4] = 32'hFFFFFFFF; specials[5] = 32'h00010000;

        start = 1'b0; isSigned = 1'b0; opA = '0; opB = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy",  64'(busy),     64'd0);
        chk("reset.done",  64'(done),     64'd0);
        chk("reset.regwr", 64'(regWrite), 64'd0);
        chk("reset.hi",    64'(hiOut),    64'd0);
        chk("reset.lo",    64'(loOut),    64'd0);
        @(negedge clk) rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 10; i++)
            full_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                       vecs[i].exp_hi, vecs[i].exp_lo);

        // Start pulse while busy is ignored: one done pulse, original product.
`ifdef MULT_EARLY_EXIT_EN
        glitch = 2;
`else
        glitch = 10;
`endif
        @(negedge clk);
        opA = 32'd6; opB = 32'd7; isSigned = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; nd = 0; hi = '1; lo = '1;
        for (int j = 0; j < 60; j++) begin
            if (j == glitch) begin
                start = 1'b1; opA = 32'd1; opB = 32'd1; isSigned = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) begin nd++; hi = hiOut; lo = loOut; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("ignstart.ndone", 64'(nd), 64'd1);
        chk("ignstart.hi",    64'(hi), 64'd0);
        chk("ignstart.lo",    64'(lo), 64'd42);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        opA = 32'hFFFFFFFF; opB = 32'hFFFFFFFF; isSigned = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst.busy",  64'(busy),     64'd0);
        chk("midrst.done",  64'(done),     64'd0);
        chk("midrst.regwr", 64'(regWrite), 64'd0);
        chk("midrst.hi",    64'(hiOut),    64'd0);
        chk("midrst.lo",    64'(loOut),    64'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        nd = 0;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        chk("midrst.quiet", 64'(nd), 64'd0);
        full_check("postrst", 32'd3, 32'd4, 1'b0, 32'd0, 32'd12);

        // Random operations against the arithmetic reference.
        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            if ($urandom_range(0, 4) == 0) b = W'($urandom_range(0, 255));
            s = 1'($urandom);
            p = ref_prod(a, b, s);
            run_op(a, b, s, hi, lo, lat, nb, nd, rwb);
            chk($sformatf("rnd%0d.prod", i), {hi, lo}, p);
            chk($sformatf("rnd%0d.lat", i),  64'(lat), 64'(exp_lat(b, s)));
            chk($sformatf("rnd%0d.ndone", i), 64'(nd), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
